// File: rtl/stream_cipher_pkg.sv
// ---------------------------------------------------------------------------
// stream_cipher_pkg : shared constants and enums for the cipher front end
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
package stream_cipher_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_KEY   = 8'h01;
  localparam logic [7:0] CMD_DATA  = 8'h02;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    LEN  = 3'd2,
    KEY  = 3'd3,
    DATA = 3'd4,
    SKIP = 3'd5
  } router_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CMD    = 2'd1,
    ERR_KEYLEN = 2'd2,
    ERR_OVF    = 2'd3
  } err_code_e;

endpackage
`default_nettype wire

// File: rtl/cipher_frame_router.sv
// ---------------------------------------------------------------------------
// cipher_frame_router : parses SYNC/CMD/LEN framed byte stream, routes key and data payload
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
module cipher_frame_router
  import stream_cipher_pkg::*;
#(
  parameter int unsigned KEY_WIDTH_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] key_byte,
  output logic       key_byte_pulse,
  output logic       key_loaded,
  output logic [7:0] data_byte,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam logic [7:0] KEY_LEN = KEY_WIDTH_BYTES[7:0];

  router_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          cmd_is_key_q, cmd_is_key_d;
  logic [7:0]    key_byte_q, key_byte_d;
  logic          key_pulse_q, key_pulse_d;
  logic          key_loaded_q, key_loaded_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic          data_valid_q, data_valid_d;
  logic          err_pulse_q, err_pulse_d;
  err_code_e     err_code_q, err_code_d;
  logic          w_drain;

  assign w_drain = data_valid_q && data_ready;

  always_ff @(posedge clk) begin : p_state_reg
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      cmd_is_key_q <= 1'b0;
      key_byte_q   <= 8'd0;
      key_pulse_q  <= 1'b0;
      key_loaded_q <= 1'b0;
      data_byte_q  <= 8'd0;
      data_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_is_key_q <= cmd_is_key_d;
      key_byte_q   <= key_byte_d;
      key_pulse_q  <= key_pulse_d;
      key_loaded_q <= key_loaded_d;
      data_byte_q  <= data_byte_d;
      data_valid_q <= data_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        IDLE: if (rx_byte == SYNC_BYTE) state_d = CMD;
        CMD:  state_d = (rx_byte == CMD_KEY || rx_byte == CMD_DATA) ? LEN : IDLE;
        LEN: begin
          if (rx_byte == 8'd0)                      state_d = IDLE;
          else if (!cmd_is_key_q)                   state_d = DATA;
          else if (rx_byte == KEY_LEN)              state_d = KEY;
          else                                      state_d = SKIP;
        end
        KEY, DATA, SKIP: if (cnt_q == 8'd1) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin : p_outputs
    cnt_d        = cnt_q;
    cmd_is_key_d = cmd_is_key_q;
    key_byte_d   = key_byte_q;
    key_pulse_d  = 1'b0;
    key_loaded_d = key_loaded_q;
    data_byte_d  = data_byte_q;
    data_valid_d = data_valid_q && !w_drain;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    if (rx_valid) begin
      case (state_q)
        CMD: begin
          cmd_is_key_d = (rx_byte == CMD_KEY);
          if (rx_byte != CMD_KEY && rx_byte != CMD_DATA) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CMD;
          end
        end
        LEN: begin
          cnt_d = rx_byte;
          if (cmd_is_key_q) begin
            if (rx_byte == KEY_LEN) begin
              key_loaded_d = 1'b0;
            end else begin
              err_pulse_d = 1'b1;
              err_code_d  = ERR_KEYLEN;
            end
          end
        end
        KEY: begin
          cnt_d       = cnt_q - 8'd1;
          key_byte_d  = rx_byte;
          key_pulse_d = 1'b1;
          if (cnt_q == 8'd1) key_loaded_d = 1'b1;
        end
        DATA: begin
          cnt_d = cnt_q - 8'd1;
          // The single holding register may be refilled in the same cycle it drains.
          if (!data_valid_q || w_drain) begin
            data_byte_d  = rx_byte;
            data_valid_d = 1'b1;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_OVF;
          end
        end
        SKIP: cnt_d = cnt_q - 8'd1;
        default: ;
      endcase
    end
  end

  assign key_byte       = key_byte_q;
  assign key_byte_pulse = key_pulse_q;
  assign key_loaded     = key_loaded_q;
  assign data_byte      = data_byte_q;
  assign data_valid     = data_valid_q;
  assign busy           = (state_q != IDLE);
  assign err_pulse      = err_pulse_q;
  assign err_code       = err_code_q;

endmodule
`default_nettype wire
